// File: rtl/switch_debouncer_pkg.sv
// switch_debouncer_pkg: per-bit debounce FSM states and counter sizing shared by the debouncer.
package debounce_pkg;
    typedef enum logic {ST_STABLE, ST_COUNTING} state_e;
    function automatic int cnt_width(int stable_cycles);
        return $clog2(stable_cycles);
    endfunction
endpackage

// File: rtl/switch_debouncer_if.sv
// switch_debouncer_if: raw switch inputs and debounced outputs of the switch conditioner.
interface switch_debouncer_if #(parameter int WIDTH = 8);
    logic             en;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             changed;
    modport master (output en, raw, input clean, rise, fall, changed);
    modport slave (input en, raw, output clean, rise, fall, changed);
endinterface

// File: rtl/switch_debouncer_bit.sv
// debounce_bit: 2-FF synchronizer, stability counter FSM and edge strobes for one switch bit.
module debounce_bit import debounce_pkg::*; #(
    parameter int   STABLE_CYCLES = 16,
    parameter logic RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    if (STABLE_CYCLES < 2) begin : g_bad_cfg
        $error("debounce_bit: STABLE_CYCLES must be >= 2");
    end
    logic          sync1_q, sync2_q, clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;
    logic          diff;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            clean_q <= RESET_VAL;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            clean_q <= clean_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign diff = sync2_q != clean_q;
    // Strobes are registered alongside clean so they coincide with the level change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (en_i) begin
            if (state_q == ST_STABLE) begin
                state_d = diff ? ST_COUNTING : ST_STABLE;
                cnt_d   = diff ? CW'(1) : '0;
            end else if (!diff || cnt_q == LAST) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
                clean_d = diff ? ~clean_q : clean_q;
                rise_d  = diff & ~clean_q;
                fall_d  = diff & clean_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end
    assign clean_o = clean_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: debounces WIDTH slide switches; SWITCH_DEBOUNCER_CHANGED_EN enables the changed pulse.
module switch_debouncer #(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input logic                clk,
    input logic                reset,
    switch_debouncer_if.slave  bus
);
    logic [WIDTH-1:0] clean_w, rise_w, fall_w;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES), .RESET_VAL(RESET_VAL[i])) u_bit (
            .clk     (clk),
            .reset   (reset),
            .en_i    (bus.en),
            .raw_i   (bus.raw[i]),
            .clean_o (clean_w[i]),
            .rise_o  (rise_w[i]),
            .fall_o  (fall_w[i])
        );
    end
    assign bus.clean = clean_w;
    assign bus.rise  = rise_w;
    assign bus.fall  = fall_w;
`ifdef SWITCH_DEBOUNCER_CHANGED_EN
    logic changed_q;
    always_ff @(posedge clk) begin
        if (reset) changed_q <= 1'b0;
        else       changed_q <= |(rise_w | fall_w);
    end
    assign bus.changed = changed_q;
`else
    assign bus.changed = 1'b0;
`endif
endmodule
